// File: rtl/controla_tiros_if.sv
// Handshake and status bundle between the player/registration side and controla_tiros.
interface controla_tiros_if;
  logic       tiro;
  logic       tiro_registrado;
  logic [3:0] libera_tiro;
  logic       registra_tiro;
  logic [1:0] slot_tiro;
  logic [3:0] tiros_ativos;
  logic [7:0] descartes;
  logic [3:0] db_estado;

  modport master (
    output tiro, tiro_registrado, libera_tiro,
    input  registra_tiro, slot_tiro, tiros_ativos, descartes, db_estado
  );

  modport slave (
    input  tiro, tiro_registrado, libera_tiro,
    output registra_tiro, slot_tiro, tiros_ativos, descartes, db_estado
  );
endinterface

// File: rtl/controla_tiros.sv
// Shot controller: turns fire presses into registration requests for free slots,
// tracks slot occupancy, enforces a post-shot cooldown and counts dropped presses.
module controla_tiros #(
  parameter int N_SLOTS = 4,
  parameter int RECARGA = 8,
  parameter int TIMEOUT = 16
) (
  input logic               clock,
  input logic               reset,
  controla_tiros_if.slave   bus
);

  typedef enum logic [3:0] {
    ST_OCIOSO   = 4'h0,
    ST_REGISTRA = 4'h1,
    ST_RECARGA  = 4'h2
  } state_t;

  state_t      state_q, state_d;
  logic        tiro_prev_q, tiro_prev_d;
  logic [1:0]  slot_q, slot_d;
  logic [3:0]  tiros_q, tiros_d;
  logic [7:0]  descartes_q, descartes_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        press;
  logic [3:0]  free;
  logic [1:0]  free_idx;
  logic [3:0]  set_mask;

  // Lowest-index free slot; the downward scan lets the lowest index win.
  always_comb begin
    free     = ~tiros_q;
    free_idx = '0;
    for (int unsigned i = N_SLOTS; i > 0; i--) begin
      if (free[i-1]) free_idx = 2'(i - 1);
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    cnt_d       = cnt_q;
    descartes_d = descartes_q;
    set_mask    = '0;
    tiro_prev_d = bus.tiro;
    press       = bus.tiro & ~tiro_prev_q;

    case (state_q)
      ST_OCIOSO: begin
        if (press) begin
          if (|free) begin
            state_d = ST_REGISTRA;
            slot_d  = free_idx;
            cnt_d   = '0;
          end else if (descartes_q != 8'hFF) begin
            descartes_d = descartes_q + 8'd1;
          end
        end
      end
      ST_REGISTRA: begin
        if (bus.tiro_registrado) begin
          set_mask = 4'b0001 << slot_q;
          state_d  = ST_RECARGA;
          cnt_d    = '0;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = ST_OCIOSO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RECARGA: begin
        if (cnt_q == 8'(RECARGA - 1)) begin
          state_d = ST_OCIOSO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_OCIOSO;
        cnt_d   = '0;
      end
    endcase

    // Set is OR-ed after the clear so a simultaneous set/release leaves the bit set.
    tiros_d = (tiros_q & ~bus.libera_tiro) | set_mask;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_OCIOSO;
      tiro_prev_q <= 1'b0;
      slot_q      <= '0;
      tiros_q     <= '0;
      descartes_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      tiro_prev_q <= tiro_prev_d;
      slot_q      <= slot_d;
      tiros_q     <= tiros_d;
      descartes_q <= descartes_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.registra_tiro = (state_q == ST_REGISTRA);
  assign bus.slot_tiro     = slot_q;
  assign bus.tiros_ativos  = tiros_q;
  assign bus.descartes     = descartes_q;
  assign bus.db_estado     = state_q;

endmodule

// File: tb/tb_controla_tiros.sv
// Directed bench for controla_tiros: expected registration slots go through a queue
// checked by a monitor on each new request; occupancy/state checked inline.
module tb_controla_tiros;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   exp_q[$];
  logic reg_prev = 1'b0;

  controla_tiros_if bus();

  controla_tiros #(.N_SLOTS(4), .RECARGA(8), .TIMEOUT(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Monitor: every new request must match the next expected slot.
  always @(negedge clock) begin
    if (bus.registra_tiro && !reg_prev) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_request: got slot %0d want no request", bus.slot_tiro);
      end else begin
        chk("req_slot", int'(bus.slot_tiro), exp_q.pop_front());
      end
    end
    reg_prev = bus.registra_tiro;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Press, optional ack on the first request cycle, then wait out the cooldown.
  task automatic shot(input int exp_slot, input bit give_ack);
    bus.tiro = 1'b1;
    if (exp_slot >= 0) exp_q.push_back(exp_slot);
    @(negedge clock);
    bus.tiro = 1'b0;
    bus.tiro_registrado = give_ack;
    @(negedge clock);
    bus.tiro_registrado = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bus.tiro = 1'b0;
    bus.tiro_registrado = 1'b0;
    bus.libera_tiro = 4'b0000;
    @(negedge clock);
    @(negedge clock);
    chk("rst_registra", int'(bus.registra_tiro), 0);
    chk("rst_slot", int'(bus.slot_tiro), 0);
    chk("rst_ativos", int'(bus.tiros_ativos), 0);
    chk("rst_descartes", int'(bus.descartes), 0);
    chk("rst_estado", int'(bus.db_estado), 0);

    // tiro held high through reset release: exactly one shot
    bus.tiro = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_q.push_back(0);
    @(negedge clock);
    chk("p1_estado_reg", int'(bus.db_estado), 1);
    chk("p1_registra", int'(bus.registra_tiro), 1);
    bus.tiro_registrado = 1'b1;
    @(negedge clock);
    bus.tiro_registrado = 1'b0;
    chk("p1_ativos", int'(bus.tiros_ativos), 4'b0001);
    chk("p1_recarga_0", int'(bus.db_estado), 2);
    for (int i = 1; i < 8; i++) begin
      @(negedge clock);
      chk("p1_recarga_n", int'(bus.db_estado), 2);
    end
    @(negedge clock);
    chk("p1_ocioso", int'(bus.db_estado), 0);
    repeat (5) @(negedge clock);
    chk("p1_no_repeat", int'(bus.tiros_ativos), 4'b0001);
    bus.tiro = 1'b0;
    @(negedge clock);

    // Fill all four slots, fifth press dropped
    do_reset();
    shot(0, 1'b1); chk("fill1", int'(bus.tiros_ativos), 4'b0001);
    shot(1, 1'b1); chk("fill2", int'(bus.tiros_ativos), 4'b0011);
    shot(2, 1'b1); chk("fill3", int'(bus.tiros_ativos), 4'b0111);
    shot(3, 1'b1); chk("fill4", int'(bus.tiros_ativos), 4'b1111);
    shot(-1, 1'b1);
    chk("drop_descartes", int'(bus.descartes), 1);
    chk("drop_ativos", int'(bus.tiros_ativos), 4'b1111);
    chk("drop_estado", int'(bus.db_estado), 0);

    // Saturation of the drop counter
    for (int i = 0; i < 300; i++) begin
      bus.tiro = 1'b1;
      @(negedge clock);
      bus.tiro = 1'b0;
      @(negedge clock);
    end
    chk("descartes_sat", int'(bus.descartes), 255);

    // Free slot 2, next press reuses it
    bus.libera_tiro = 4'b0100;
    @(negedge clock);
    bus.libera_tiro = 4'b0000;
    chk("free2_ativos", int'(bus.tiros_ativos), 4'b1011);
    shot(2, 1'b1);
    chk("reuse2_ativos", int'(bus.tiros_ativos), 4'b1111);

    // Timeout: no ack for slot 3
    bus.libera_tiro = 4'b1000;
    @(negedge clock);
    bus.libera_tiro = 4'b0000;
    chk("free3_ativos", int'(bus.tiros_ativos), 4'b0111);
    bus.tiro = 1'b1;
    exp_q.push_back(3);
    @(negedge clock);
    bus.tiro = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.registra_tiro) break;
      n++;
      @(negedge clock);
    end
    chk("timeout_cycles", n, 16);
    chk("timeout_estado", int'(bus.db_estado), 0);
    chk("timeout_ativos", int'(bus.tiros_ativos), 4'b0111);

    // Release during REGISTRA keeps latched slot; ack + release of same slot -> set wins
    bus.tiro = 1'b1;
    exp_q.push_back(3);
    @(negedge clock);
    bus.tiro = 1'b0;
    bus.libera_tiro = 4'b0001;
    @(negedge clock);
    bus.libera_tiro = 4'b0000;
    chk("latch_slot", int'(bus.slot_tiro), 3);
    chk("latch_ativos", int'(bus.tiros_ativos), 4'b0110);
    chk("latch_estado", int'(bus.db_estado), 1);
    bus.tiro_registrado = 1'b1;
    bus.libera_tiro = 4'b1000;
    @(negedge clock);
    bus.tiro_registrado = 1'b0;
    bus.libera_tiro = 4'b0000;
    chk("setwins_ativos", int'(bus.tiros_ativos), 4'b1110);
    chk("setwins_estado", int'(bus.db_estado), 2);
    repeat (10) @(negedge clock);

    // Reset aborts RECARGA
    do_reset();
    shot(0, 1'b1);
    bus.tiro = 1'b1;
    exp_q.push_back(1);
    @(negedge clock);
    bus.tiro = 1'b0;
    bus.tiro_registrado = 1'b1;
    @(negedge clock);
    bus.tiro_registrado = 1'b0;
    chk("pre_rst_estado", int'(bus.db_estado), 2);
    chk("pre_rst_ativos", int'(bus.tiros_ativos), 4'b0011);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_estado", int'(bus.db_estado), 0);
    chk("abort_ativos", int'(bus.tiros_ativos), 0);
    chk("abort_registra", int'(bus.registra_tiro), 0);
    chk("abort_slot", int'(bus.slot_tiro), 0);
    chk("abort_descartes", int'(bus.descartes), 0);
    repeat (3) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
